uart_msg_gen: RTL and testbench

- Parametrised character-stream generator feeding a uart_tx-style sink over a valid/ready byte handshake.
- Emits an incrementing character sequence of configurable start value and length, with optional CR/LF terminator and inter-character gap.
- Supports single-pass and continuous modes.
- Replaces fixed A–Z bring-up stimulus; used for board bring-up and as a UART traffic source in system sims.

---
 rtl/uart_msg_gen.sv | 173 +++++++++++++++++
 tb/tb_uart_msg_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_gen.sv
// Character-stream generator: incrementing chars from START_CHAR, optional CR/LF, optional gap.
// Latency: first character valid one cycle after start is sampled; back-to-back when GAP_CYCLES=0.
// Backpressure: dvalid/data held stable until ready; the stream stalls and nothing is dropped.
module uart_msg_gen #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned START_CHAR  = 8'h41,
  parameter int unsigned NUM_CHARS   = 26,
  parameter bit          APPEND_CRLF = 1'b1,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              mode,
  input  logic              stop,
  input  logic              ready,
  output logic              dvalid,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        char_idx,
  output logic [15:0]       pass_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHAR = 3'd1;
  localparam logic [2:0] S_CR   = 3'd2;
  localparam logic [2:0] S_LF   = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [DATA_W-1:0] START_W   = DATA_W'(START_CHAR);
  localparam logic [DATA_W-1:0] CR_W      = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] LF_W      = DATA_W'(8'h0A);
  localparam logic [7:0]        LAST_IDX  = 8'(NUM_CHARS - 1);
  localparam logic [15:0]       GAP_LOAD  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam bit                USE_GAP   = (GAP_CYCLES > 0);

  logic [2:0]        state_q, state_d, nxt_q, nxt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        idx_q, idx_d;
  logic [15:0]       pass_q, pass_d, gap_q, gap_d;
  logic              mode_q, mode_d, stop_pend_q, stop_pend_d, done_q, done_d;

  logic              xfer, stop_now, last_char, final_item;
  logic [2:0]        succ_state;
  logic [DATA_W-1:0] succ_data;

  assign dvalid     = (state_q == S_CHAR) || (state_q == S_CR) || (state_q == S_LF);
  assign xfer       = dvalid && ready;
  assign stop_now   = stop || stop_pend_q;
  assign last_char  = (state_q == S_CHAR) && (idx_q == LAST_IDX);
  assign final_item = APPEND_CRLF ? (state_q == S_LF) : last_char;

  // Successor of the item currently presented; IDLE means the pass ends in single mode.
  always_comb begin
    succ_state = S_IDLE;
    succ_data  = '0;
    if (final_item) begin
      if (mode_q) begin
        succ_state = S_CHAR;
        succ_data  = START_W;
      end
    end else if (state_q == S_CHAR && last_char) begin
      succ_state = S_CR;
      succ_data  = CR_W;
    end else if (state_q == S_CHAR) begin
      succ_state = S_CHAR;
      succ_data  = START_W + DATA_W'(idx_q + 8'd1);
    end else if (state_q == S_CR) begin
      succ_state = S_LF;
      succ_data  = LF_W;
    end
  end

  // Next-state logic for sequencing, handshake, gap timing and stop handling.
  always_comb begin
    state_d     = state_q;
    nxt_d       = nxt_q;
    data_d      = data_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    gap_d       = gap_q;
    mode_d      = mode_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CHAR;
          data_d      = START_W;
          mode_d      = mode;
          idx_d       = 8'd0;
          stop_pend_d = 1'b0;
        end
      end
      S_CHAR, S_CR, S_LF: begin
        if (stop) stop_pend_d = 1'b1;
        if (xfer) begin
          if (state_q == S_CHAR) idx_d = idx_q + 8'd1;
          if (final_item) begin
            pass_d = pass_q + 16'd1;
            idx_d  = 8'd0;
          end
          if (stop_now) begin
            state_d     = S_IDLE;
            done_d      = 1'b1;
            idx_d       = 8'd0;
            stop_pend_d = 1'b0;
          end else if (USE_GAP) begin
            state_d = S_GAP;
            nxt_d   = succ_state;
            data_d  = succ_data;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = succ_state;
            data_d  = succ_data;
            done_d  = (succ_state == S_IDLE);
          end
        end
      end
      S_GAP: begin
        if (stop_now) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          idx_d       = 8'd0;
          stop_pend_d = 1'b0;
        end else if (gap_q == 16'd0) begin
          state_d = nxt_q;
          done_d  = (nxt_q == S_IDLE);
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any pass with no done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      nxt_q       <= S_IDLE;
      data_q      <= '0;
      idx_q       <= 8'd0;
      pass_q      <= 16'd0;
      gap_q       <= 16'd0;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nxt_q       <= nxt_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      gap_q       <= gap_d;
      mode_q      <= mode_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  assign data     = dvalid ? data_q : '0;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign char_idx = idx_q;
  assign pass_cnt = pass_q;

  // A zero-length pass has no meaningful final item.
  a_num_chars: assert property (@(posedge clk) disable iff (!resetn)
    (NUM_CHARS >= 1 && NUM_CHARS <= 255));

endmodule

// File: tb/tb_uart_msg_gen.sv
module tb_uart_msg_gen;

  logic clk, resetn;

  logic st0, md0, sp0, rd0, dv0, bz0, dn0;
  logic [7:0] dt0, ci0;
  logic [15:0] pc0;
  logic st1, md1, sp1, rd1, dv1, bz1, dn1;
  logic [7:0] dt1, ci1;
  logic [15:0] pc1;
  logic st2, md2, sp2, rd2, dv2, bz2, dn2;
  logic [7:0] dt2, ci2;
  logic [15:0] pc2;
  logic st3, md3, sp3, rd3, dv3, bz3, dn3;
  logic [7:0] dt3, ci3;
  logic [15:0] pc3;

  int n_chk;
  int n_err;

  uart_msg_gen u0 (
    .clk(clk), .resetn(resetn), .start(st0), .mode(md0), .stop(sp0), .ready(rd0),
    .dvalid(dv0), .data(dt0), .busy(bz0), .done(dn0), .char_idx(ci0), .pass_cnt(pc0));

  uart_msg_gen #(.NUM_CHARS(2), .APPEND_CRLF(1'b0), .GAP_CYCLES(3)) u1 (
    .clk(clk), .resetn(resetn), .start(st1), .mode(md1), .stop(sp1), .ready(rd1),
    .dvalid(dv1), .data(dt1), .busy(bz1), .done(dn1), .char_idx(ci1), .pass_cnt(pc1));

  uart_msg_gen #(.NUM_CHARS(3), .APPEND_CRLF(1'b0)) u2 (
    .clk(clk), .resetn(resetn), .start(st2), .mode(md2), .stop(sp2), .ready(rd2),
    .dvalid(dv2), .data(dt2), .busy(bz2), .done(dn2), .char_idx(ci2), .pass_cnt(pc2));

  uart_msg_gen #(.START_CHAR(8'hFE), .NUM_CHARS(4), .APPEND_CRLF(1'b0)) u3 (
    .clk(clk), .resetn(resetn), .start(st3), .mode(md3), .stop(sp3), .ready(rd3),
    .dvalid(dv3), .data(dt3), .busy(bz3), .done(dn3), .char_idx(ci3), .pass_cnt(pc3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    logic       gap_dv  [8];
    logic [7:0] gap_dat [8];
    logic [7:0] wrap_dat [4];
    gap_dv   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    gap_dat  = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h42, 8'h00, 8'h00, 8'h00};
    wrap_dat = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    n_chk = 0;
    n_err = 0;
    clk = 1'b0;
    resetn = 1'b0;
    {st0, md0, sp0, rd0} = '0;
    {st1, md1, sp1, rd1} = '0;
    {st2, md2, sp2, rd2} = '0;
    {st3, md3, sp3, rd3} = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // reset values
    chk("rst_dvalid", 32'(dv0), 32'd0);
    chk("rst_busy",   32'(bz0), 32'd0);
    chk("rst_data",   32'(dt0), 32'd0);
    chk("rst_done",   32'(dn0), 32'd0);
    chk("rst_idx",    32'(ci0), 32'd0);
    chk("rst_pass",   32'(pc0), 32'd0);

    // default single pass: A..Z CR LF back-to-back
    rd0 = 1'b1; md0 = 1'b0; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    for (int i = 0; i < 28; i++) begin
      if (i < 26) e = 8'(8'h41 + i);
      else if (i == 26) e = 8'h0D;
      else e = 8'h0A;
      chk("seq_dvalid", 32'(dv0), 32'd1);
      chk("seq_data",   32'(dt0), 32'(e));
      chk("seq_nodone", 32'(dn0), 32'd0);
      @(negedge clk);
    end
    chk("seq_done",   32'(dn0), 32'd1);
    chk("seq_busy",   32'(bz0), 32'd0);
    chk("seq_pass",   32'(pc0), 32'd1);
    chk("seq_dv_end", 32'(dv0), 32'd0);
    chk("seq_dt_end", 32'(dt0), 32'd0);
    @(negedge clk);
    chk("seq_done_clr", 32'(dn0), 32'd0);

    // backpressure on 'C'
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_pre_data", 32'(dt0), 32'h43);
    rd0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_dv",   32'(dv0), 32'd1);
      chk("bp_hold_data", 32'(dt0), 32'h43);
      chk("bp_hold_idx",  32'(ci0), 32'd2);
    end
    rd0 = 1'b1;
    @(negedge clk);
    chk("bp_next_data", 32'(dt0), 32'h44);
    chk("bp_next_idx",  32'(ci0), 32'd3);

    // asynchronous reset mid-pass
    #2 resetn = 1'b0;
    #1;
    chk("ar_dvalid", 32'(dv0), 32'd0);
    chk("ar_busy",   32'(bz0), 32'd0);
    chk("ar_idx",    32'(ci0), 32'd0);
    chk("ar_pass",   32'(pc0), 32'd0);
    chk("ar_data",   32'(dt0), 32'd0);
    chk("ar_done",   32'(dn0), 32'd0);
    @(negedge clk);
    chk("ar_done_hold", 32'(dn0), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    chk("ar_restart_dv",   32'(dv0), 32'd1);
    chk("ar_restart_data", 32'(dt0), 32'h41);
    sp0 = 1'b1;
    @(negedge clk);
    sp0 = 1'b0;
    chk("stop1_done", 32'(dn0), 32'd1);
    chk("stop1_busy", 32'(bz0), 32'd0);
    chk("stop1_idx",  32'(ci0), 32'd0);
    chk("stop1_pass", 32'(pc0), 32'd0);

    // inter-character gap of 3 cycles
    rd1 = 1'b1; st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("gap_dvalid", 32'(dv1), 32'(gap_dv[i]));
      chk("gap_data",   32'(dt1), 32'(gap_dat[i]));
      chk("gap_busy",   32'(bz1), 32'd1);
      chk("gap_nodone", 32'(dn1), 32'd0);
      @(negedge clk);
    end
    chk("gap_done", 32'(dn1), 32'd1);
    chk("gap_pass", 32'(pc1), 32'd1);
    chk("gap_idle", 32'(bz1), 32'd0);

    // continuous mode, stop on second 'B'
    rd2 = 1'b1; md2 = 1'b1; st2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0; md2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = 8'(8'h41 + (i % 3));
      chk("cont_dvalid", 32'(dv2), 32'd1);
      chk("cont_data",   32'(dt2), 32'(e));
      chk("cont_nodone", 32'(dn2), 32'd0);
      if (i == 2) chk("cont_pass0", 32'(pc2), 32'd0);
      if (i == 3) chk("cont_pass1", 32'(pc2), 32'd1);
      if (i == 4) sp2 = 1'b1;
      @(negedge clk);
    end
    sp2 = 1'b0;
    chk("cont_stop_done", 32'(dn2), 32'd1);
    chk("cont_stop_busy", 32'(bz2), 32'd0);
    chk("cont_stop_pass", 32'(pc2), 32'd1);
    chk("cont_stop_idx",  32'(ci2), 32'd0);
    chk("cont_stop_dv",   32'(dv2), 32'd0);

    // character wrap past 0xFF
    rd3 = 1'b1; st3 = 1'b1;
    @(negedge clk);
    st3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_dvalid", 32'(dv3), 32'd1);
      chk("wrap_data",   32'(dt3), 32'(wrap_dat[i]));
      @(negedge clk);
    end
    chk("wrap_done", 32'(dn3), 32'd1);
    chk("wrap_pass", 32'(pc3), 32'd1);
    chk("wrap_busy", 32'(bz3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
